fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          C_DEFAULT_DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction buffer of DEPTH {pc, instr} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = C_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    fetch_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_full_cnt);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so push-on-full is accepted alongside it
    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-outstanding instruction fetcher with branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC,
    parameter int          DEPTH    = C_DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int                 c_cnt_w     = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [31:0]        c_pc_step   = 32'd4;

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    fetch_state_t       w_rst_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic               w_room;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;

    // At most one request is ever in flight, so free space now covers its response
    assign w_room       = (w_count < c_depth_cnt);
    assign w_grant      = imem_req & imem_gnt;
    assign w_pop        = instr_valid & instr_ready & ~br_taken;
    assign w_push_entry = {r_resp_pc, imem_rdata};
    assign imem_addr    = r_fetch_pc;

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                imem_req = w_room & ~br_taken & ~rst;
                if (imem_req && imem_gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_push      = ~br_taken;
                    w_state_nxt = IDLE;
                end else if (br_taken) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Only a request caught mid-flight needs its late response swallowed; any
    // other state (including power-up garbage) restarts cleanly in IDLE.
    always_comb begin
        w_rst_state = IDLE;
        if (r_state == WAIT && !imem_rvalid) begin
            w_rst_state = DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= w_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= align_word(RESET_PC);
            r_resp_pc  <= '0;
        end else begin
            if (br_taken) begin
                r_fetch_pc <= align_word(br_target);
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + c_pc_step;
            end
            if (w_grant) begin
                r_resp_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push & (~w_full | w_pop)),
        .pop       (w_pop),
        .flush     (br_taken),
        .push_data (w_push_entry),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign instr_valid = ~w_empty;
    assign instr       = w_empty ? 32'h0 : w_head.instr;
    assign pc          = w_empty ? 32'h0 : w_head.pc;

endmodule
`default_nettype wire
